// File: rtl/rr_fifo_arbiter_pkg.sv
// rr_fifo_arbiter_pkg: shared definitions for the round-robin FIFO arbiter.
//   - arb_state_e : arbiter FSM states (idle / burst)
//   - DEF_*       : default values of the N, M, R and BURST parameters
//   - cnt_width   : counter width helper that never returns zero
package rr_fifo_arbiter_pkg;

    localparam int unsigned DEF_N     = 4;   // data width per requester
    localparam int unsigned DEF_M     = 16;  // FIFO depth (usable M-1)
    localparam int unsigned DEF_R     = 4;   // number of requesters
    localparam int unsigned DEF_BURST = 4;   // max writes per grant

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    // $clog2 of 1 is 0, which would give a zero-width vector.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/shared_fifo.sv
// shared_fifo: single-clock circular FIFO with registered read data.
//   i_clk      : clock, rising edge
//   i_reset    : asynchronous active-low reset (pointers and read data cleared)
//   i_wr_en    : push request, ignored when full
//   i_wr_data  : push data
//   i_rd_en    : pop request, ignored when empty
//   o_rd_data  : registered pop data, holds its value when nothing is popped
//   o_full     : M-1 entries stored (one slot kept free to tell full from empty)
//   o_empty    : no entries stored
module shared_fifo
    import rr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned M = DEF_M
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr_en,
    input  logic [N-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [N-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = cnt_width(M);

    logic [N-1:0]  r_mem [M];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [N-1:0]  r_rd_data;
    logic [AW-1:0] w_wptr_inc;
    logic          w_push;
    logic          w_pop;

    // Pointers wrap naturally because M is a power of two.
    assign w_wptr_inc = r_wptr + 1'b1;
    assign o_full     = (w_wptr_inc == r_rptr);
    assign o_empty    = (r_wptr == r_rptr);
    assign w_push     = i_wr_en && !o_full;
    assign w_pop      = i_rd_en && !o_empty;
    assign o_rd_data  = r_rd_data;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: round-robin arbiter granting bursts of up to BURST writes from R
// requesters into one shared FIFO.
//   i_clk      : clock, rising edge
//   i_reset    : asynchronous active-low reset
//   i_req      : per-requester write request
//   i_wr_data  : requester i data in bits [i*N +: N]
//   o_grant    : one-hot, slice o_owner is written this cycle
//   o_owner    : current burst owner, valid while o_busy
//   o_busy     : arbiter is in a burst
//   i_read_en  : pop request from the consumer
//   o_data_out : registered FIFO read data
//   o_full     : FIFO full flag
//   o_empty    : FIFO empty flag
module rr_fifo_arbiter
    import rr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned M     = DEF_M,
    parameter int unsigned R     = DEF_R,
    parameter int unsigned BURST = DEF_BURST
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [R-1:0]         i_req,
    input  logic [R*N-1:0]       i_wr_data,
    output logic [R-1:0]         o_grant,
    output logic [$clog2(R)-1:0] o_owner,
    output logic                 o_busy,
    input  logic                 i_read_en,
    output logic [N-1:0]         o_data_out,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned OW = $clog2(R);
    localparam int unsigned BW = cnt_width(BURST);
    localparam logic [BW-1:0] LastBeat = BW'(BURST - 1);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] w_owner_nxt;
    logic [OW-1:0] r_last_owner;
    logic [OW-1:0] w_last_owner_nxt;
    logic [BW-1:0] r_beat_cnt;
    logic [BW-1:0] w_beat_cnt_nxt;
    logic [R-1:0]  w_grant;
    logic [OW-1:0] w_winner;
    logic [OW-1:0] w_idx;
    logic          w_found;
    logic [N-1:0]  w_wr_slice;
    logic          w_full;
    logic          w_empty;

    // Round-robin search starting just after the previous owner. R is a power of
    // two, so the OW-bit sum wraps modulo R; k == R revisits last_owner itself.
    always_comb begin
        w_winner = r_last_owner;
        w_found  = 1'b0;
        w_idx    = r_last_owner;
        for (int unsigned k = 1; k <= R; k++) begin
            w_idx = r_last_owner + OW'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_grant          = '0;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_nxt    = StBurst;
                    w_owner_nxt    = w_winner;
                    w_beat_cnt_nxt = '0;
                end
            end
            StBurst: begin
                if (!i_req[r_owner]) begin
                    w_state_nxt      = StIdle;
                    w_last_owner_nxt = r_owner;
                end else if (!w_full) begin
                    w_grant[r_owner] = 1'b1;
                    w_beat_cnt_nxt   = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == LastBeat) begin
                        w_state_nxt      = StIdle;
                        w_last_owner_nxt = r_owner;
                    end
                end
                // Full with request held: stall with everything frozen.
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_owner      <= '0;
            r_last_owner <= OW'(R - 1);  // requester 0 wins first after reset
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    assign w_wr_slice = i_wr_data[r_owner*N +: N];

    shared_fifo #(
        .N (N),
        .M (M)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (|w_grant),
        .i_wr_data (w_wr_slice),
        .i_rd_en   (i_read_en),
        .o_rd_data (o_data_out),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign o_grant = w_grant;
    assign o_owner = r_owner;
    assign o_busy  = (r_state == StBurst);
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: doc/rr_fifo_arbiter.md
RR_FIFO_ARBITER -- requirements
Module: rr_fifo_arbiter

Interface
REQ-001 Parameter N, default 4: data width per requester.
REQ-002 Parameter M, default 16: FIFO depth (power of two); usable capacity M-1.
REQ-003 Parameter R, default 4: number of requesters (power of two, >=2).
REQ-004 Parameter BURST, default 4: max consecutive writes per grant.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 req  input  R  per-requester write request, held until granted beats are done.
REQ-008 wr_data  input  R*N  requester i data in bits [i*N +: N].
REQ-009 grant  output  R  one-hot; grant[i]=1 means wr_data slice i is written this cycle.
REQ-010 owner  output  $clog2(R)  index of current burst owner; valid when busy=1.
REQ-011 busy  output  1  high while FSM in BURST.
REQ-012 read_en  input  1  pop request from consumer.
REQ-013 data_out  output  N  registered read data.
REQ-014 full, empty  output  1 each  FIFO status flags.

Function
REQ-015 FSM states IDLE and BURST; owner, last_owner and beat_cnt ($clog2(BURST) bits) are registers.
REQ-016 IDLE: if any req bit set, pick first set bit searching from last_owner+1 modulo R upward; next cycle state=BURST, owner=winner, beat_cnt=0; no write in IDLE.
REQ-017 IDLE with req=0: remain IDLE, grant=0.
REQ-018 BURST: grant[owner] combinationally = req[owner] && !full; all other grant bits 0.
REQ-019 Each granted cycle writes wr_data slice owner into FIFO and increments beat_cnt.
REQ-020 BURST exits to IDLE (last_owner<=owner) after the granted cycle with beat_cnt==BURST-1, or in any cycle req[owner]=0.
REQ-021 full in BURST: grant low, beat_cnt holds, state holds (stall, no timeout).
REQ-022 Latency: first write of a burst one cycle after IDLE detects req; back-to-back bursts separated by exactly one IDLE cycle.
REQ-023 FIFO: write/read pointers $clog2(M) bits, wrap modulo M; full = (wptr+1 == rptr); empty = (wptr == rptr).
REQ-024 Write ignored when full; read ignored when empty; data_out holds last value on no-pop.
REQ-025 read_en && !empty: data_out <= entry at rptr, visible one cycle later; rptr++.
REQ-026 Simultaneous write and read in one cycle both take effect when respective flags permit; flags are evaluated before the edge.
REQ-027 Ordering: data popped in exact write order; no requester starved: any held req granted within R-1 other bursts.

Reset
REQ-028 reset low asynchronously forces: state=IDLE, owner=0, last_owner=R-1 (requester 0 wins first), beat_cnt=0, pointers=0, data_out=0.
REQ-029 During reset: grant=0, busy=0, empty=1, full=0.
REQ-030 Reset mid-burst aborts burst and discards all FIFO contents; no write occurs in the deassertion cycle unless BURST is re-entered per REQ-016.

Structure
REQ-031 Shared package holds the state enum (IDLE, BURST) and default values of N, M, R, BURST.
REQ-032 FIFO storage, pointers and flags live in one sub-module shared_fifo; arbiter FSM in top level.

Verification
REQ-033 Single requester: req=0001, data 1,2,3,4,5 -> first grant one cycle after req, four grants, one IDLE cycle, then grant for 5; pops return 1..5.
REQ-034 All four requesting constantly -> owner sequence 0,1,2,3,0; each burst exactly 4 writes.
REQ-035 Fill: no reads, 4 requesters -> exactly 15 writes accepted, full=1, grant=0 while stalled; one pop -> full=0, one more grant.
REQ-036 Early drop: req[2] released after 2 beats -> FSM to IDLE, next owner is 3 if requesting.
REQ-037 Simultaneous push and pop at 8 entries for 10 cycles -> occupancy stays 8, data_out order preserved.
REQ-038 Reset asserted mid-burst with 6 entries -> grant=0, empty=1, data_out=0 immediately; after release requester 0 served first.
